// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Bit-clock index at which a bit window is sampled.
  function automatic int mid_sample(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side handshake plus serial line of the UART receiver; master = receiver, slave = line driver/consumer.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 data_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    input  rx,
    input  data_ready,
    output data,
    output data_valid,
    output frame_err,
    output overrun,
    output busy
  );

  modport slave (
    output rx,
    output data_ready,
    input  data,
    input  data_valid,
    input  frame_err,
    input  overrun,
    input  busy
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for asynchronous level inputs; 2 clk latency, flops reset to RST_VAL.
module uart_rx_sync #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, byte held on valid/ready until accepted, overrun drops the new byte.
// UART_RX_MAJORITY_EN: each bit is a 2-of-3 vote at MID-1..MID+1 (decision one clk later, needs CLKS_PER_BIT>=3).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_rx_if.master bus
);
  localparam int MID = mid_sample(CLKS_PER_BIT);
`ifdef UART_RX_MAJORITY_EN
  localparam int SAMP = MID + 1;
`else
  localparam int SAMP = MID;
`endif
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] C_SAMP = CW'(SAMP);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_ALL  = BW'(DATA_BITS);

  uart_rx_state_t       r_state;
  logic [CW-1:0]        r_clk_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_data_valid;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 r_busy;

  logic w_rx_s;
  logic w_bit;
  logic w_at_samp;
  logic w_at_last;
  logic w_last_bit;
  logic w_accept;

  uart_rx_sync #(
    .WIDTH  (1),
    .RST_VAL(UART_IDLE_LEVEL)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (bus.rx),
    .o_q  (w_rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic r_h1;
  logic r_h2;

  if (CLKS_PER_BIT < 3) begin : g_cpb_check
    $error("uart_rx: UART_RX_MAJORITY_EN requires CLKS_PER_BIT >= 3");
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h1 <= UART_IDLE_LEVEL;
      r_h2 <= UART_IDLE_LEVEL;
    end else begin
      r_h1 <= w_rx_s;
      r_h2 <= r_h1;
    end
  end

  assign w_bit = (r_h2 & r_h1) | (r_h2 & w_rx_s) | (r_h1 & w_rx_s);
`else
  assign w_bit = w_rx_s;
`endif

  assign w_at_samp  = (r_clk_cnt == C_SAMP);
  assign w_at_last  = (r_clk_cnt == C_LAST);
  assign w_accept   = r_data_valid & bus.data_ready;
  // When the sample and the window end coincide, the count has not yet advanced.
  assign w_last_bit = w_at_samp ? (r_bit_cnt == B_LAST) : (r_bit_cnt == B_ALL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_clk_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      if (w_accept) r_data_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_rx_s != UART_IDLE_LEVEL) begin
            r_busy    <= 1'b1;
            r_bit_cnt <= '0;
            if (CLKS_PER_BIT == 1) begin
              r_state   <= DATA;
              r_clk_cnt <= '0;
            end else begin
              r_state   <= START;
              r_clk_cnt <= CW'(1);
            end
          end
        end

        START: begin
          if (w_at_samp && w_bit == UART_IDLE_LEVEL) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_clk_cnt <= '0;
          end else if (w_at_last) begin
            r_state   <= DATA;
            r_clk_cnt <= '0;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end

        DATA: begin
          if (w_at_samp) begin
            r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + BW'(1);
          end
          if (w_at_last) begin
            r_clk_cnt <= '0;
            if (w_last_bit) r_state <= STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end

        STOP: begin
          if (w_at_samp) begin
            r_clk_cnt <= '0;
            if (w_bit == UART_IDLE_LEVEL) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              // A same-edge accept frees the holding register for the new byte.
              if (!r_data_valid || w_accept) begin
                r_data       <= r_shift;
                r_data_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_state     <= WAIT_HIGH;
              r_frame_err <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end

        WAIT_HIGH: begin
          if (w_rx_s == UART_IDLE_LEVEL) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data       = r_data;
  assign bus.data_valid = r_data_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.overrun    = r_overrun;
  assign bus.busy       = r_busy;
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial-to-parallel UART receiver that consumes the 8N1 line driven by the existing transmitter stage: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1).
- Line idles high.
- Samples the line at mid-bit and presents the byte with a valid/ready handshake.
- Flags framing errors and overruns.
- Sits at the chip boundary; feeds downstream byte consumers.

Parameters:
CLKS_PER_BIT, 1, clk cycles per bit; legal range 1..65535. The default of 1 matches the one-bit-per-clock transmitter.
DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
rx  input  1  serial line, asynchronous to clk
data  output  DATA_BITS  received byte, held stable while data_valid=1
data_valid  output  1  byte available; held until accepted
data_ready  input  1  consumer accepts; transfer occurs when data_valid&&data_ready at a rising edge
frame_err  output  1  1-cycle pulse: stop bit sampled 0
overrun  output  1  1-cycle pulse: frame completed while data_valid still 1
busy  output  1  1 in any state other than IDLE

Behaviour:
- Reset: one clock; reset is synchronous and active-low (rst_n sampled on rising clk). Reset values:
  - data=0, data_valid=0, frame_err=0, overrun=0, busy=0.
  - state=IDLE, bit counters=0.
  - synchronizer flops=1.
  - Reset mid-frame abandons the frame with no pulses.
- Input sync: rx goes through a 2-flop synchronizer to give rx_s. Latency is 2 clk.
- Sample point: MID=(CLKS_PER_BIT-1)/2 (integer division). Each bit window is CLKS_PER_BIT cycles; bit-clock counter runs 0..CLKS_PER_BIT-1.
- IDLE:
  - rx_s==0 marks bit-clock 0 of the start bit; go to START.
  - For CLKS_PER_BIT=1, the detection cycle is itself the start sample, so go directly to DATA.
- START: at bit-clock MID, rx_s==1 is a glitch and returns to IDLE with no pulse. rx_s==0 continues; DATA begins at the next window.
- DATA:
  - At MID of each window, shift rx_s into the shift register LSB-first.
  - After DATA_BITS samples, go to STOP.
- STOP, at MID:
  - rx_s==1 with data_valid==0: load data, set data_valid at that same edge, go to IDLE. Re-arming at mid-stop permits back-to-back frames.
  - rx_s==1 with data_valid==1: pulse overrun, discard the new byte (data unchanged), go to IDLE.
  - rx_s==0: pulse frame_err, data and data_valid unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. This covers a break condition.
- Handshake:
  - data_valid clears at the edge where data_valid&&data_ready.
  - If a new frame's stop sample falls on that same edge, it counts as accepted-then-loaded: data_valid stays 1, data takes the new byte, no overrun.
- Latency: rx first low at edge t gives a stop sample at edge t+2+(DATA_BITS+1)*CLKS_PER_BIT+MID. For CLKS_PER_BIT=1, DATA_BITS=8, data_valid goes high at edge t+11.
- Counters are sized with $clog2(CLKS_PER_BIT+1) and $clog2(DATA_BITS+1); no wrap occurs inside a frame.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined: each bit value is the 2-of-3 majority of rx_s at bit-clocks MID-1, MID, MID+1. Start validation uses the majority. Requires CLKS_PER_BIT>=3; elaboration error otherwise.
- Undefined: single sample at MID. No extra flops.

Decomposition:
- Package uart_pkg:
  - state enum uart_rx_state_t {IDLE, START, DATA, STOP, WAIT_HIGH}.
  - localparam UART_IDLE_LEVEL=1'b1.
  - Function mid_sample(clks_per_bit).
- Sub-module uart_rx_sync: parameterised 2-flop synchronizer with reset value 1. The future transmitter-side CTS input reuses it.

Test Plan:
1. CLKS_PER_BIT=1; drive start, 0xA5 LSB-first, stop starting at edge t -> data_valid high after edge t+11, data=0xA5, no frame_err/overrun.
2. CLKS_PER_BIT=16; frames 0x00, 0xFF, 0x3C back-to-back with data_ready=1 -> three valid transfers in order; busy=0 only between mid-stop and the next start.
3. CLKS_PER_BIT=16; 0x55 sent with stop bit forced 0, then line held low 40 cycles -> single frame_err pulse, data_valid stays 0, busy=1 until rx high, then IDLE.
4. CLKS_PER_BIT=16; 0x12 received with data_ready=0, then 0x34 -> overrun pulse at 0x34 stop sample, data stays 0x12; then data_ready=1 -> data_valid drops the next edge.
5. CLKS_PER_BIT=16; rx low for 4 cycles then high -> no data_valid, returns to IDLE, busy pulses ≤ MID+1 cycles. With UART_RX_MAJORITY_EN, a 1-cycle glitch at mid-bit of data bit 3 in 0x00 -> data=0x00.
6. Assert rst_n=0 for 1 cycle mid-DATA of a frame -> all outputs 0 next edge; the following clean frame 0x81 is received correctly.
